arb_rr_n: RTL and testbench

- Parametrised N-requester arbiter, successor to the 2-requester fixed-priority arbiter used behind the arbiter interface.
- Registered one-hot grant with an encoded grant index and a valid flag.
- Grant is parked while the owner holds its request; an optional hold limit forces hand-off when others are waiting.
- Sits between requesting agents and a shared resource; testbenches drive it through a clocking block, so all outputs are registered.

---
 rtl/arb_rr_n_if.sv | 29 ++
 rtl/arb_rr_n.sv | 230 +++++++++++++++++++++++
 tb/tb_arb_rr_n.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/arb_rr_n_if.sv
// Handshake bundle between requesting agents and the N-way arbiter.
// The master side drives request levels; the slave side (the arbiter)
// returns a registered one-hot grant, its encoded index and a valid flag.
interface arb_rr_n_if #(
    parameter int N = 4
) ();

    localparam int IDW = $clog2(N);

    logic [N-1:0]   request;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    modport master (
        output request,
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    modport slave (
        input  request,
        output grant,
        output grant_id,
        output grant_valid
    );

endinterface

// File: rtl/arb_rr_n.sv
// arb_rr_n -- N-requester arbiter with grant parking and optional hold limit.
//
// The grant stays with its owner while the owner keeps requesting. With a
// non-zero MAX_HOLD the owner is forced to hand off after MAX_HOLD
// consecutive grant cycles, but only when some other requester is waiting.
// Hand-off between owners happens without an idle cycle. All outputs are
// flop outputs; nothing combinational reaches the ports from request.
//
// Build option (macro ARB_RR_EN):
//   defined   : round-robin, search starts one past the last owner.
//   undefined : fixed priority, index 0 highest; no last-owner register.
module arb_rr_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    parameter int IDW      = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst,
    arb_rr_n_if.slave bus
);

    // Hold counter keeps one bit even when the limit is disabled so the
    // datapath stays uniform; it is then held at zero.
    localparam int               HCW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0]   HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [IDW-1:0]   LAST_IDX = IDW'(N - 1);
    localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Picks the first set bit of mask, scanning upward from start and
    // wrapping at N. The mask is rotated so the scan always runs from bit 0,
    // which keeps every index inside 0..N-1.
    function automatic logic [IDW-1:0] pick_winner(
        input logic [N-1:0]   mask,
        input logic [IDW-1:0] start
    );
        logic [N-1:0] rot;
        logic         found;
        int           off;
        int           sum;
        rot   = N'({mask, mask} >> start);
        found = 1'b0;
        off   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k[IDW-1:0]]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(start) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return sum[IDW-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e         state_q;
    state_e         state_d;
    logic [N-1:0]   grant_q;
    logic [N-1:0]   grant_d;
    logic [IDW-1:0] grant_id_q;
    logic [IDW-1:0] grant_id_d;
    logic           grant_valid_q;
    logic           grant_valid_d;
    logic [HCW-1:0] hold_cnt_q;
    logic [HCW-1:0] hold_cnt_d;
`ifdef ARB_RR_EN
    logic [IDW-1:0] last_owner_q;
    logic [IDW-1:0] last_owner_d;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N-1:0]   request_s;
    logic [N-1:0]   others_s;
    logic [N-1:0]   win_mask_s;
    logic [N-1:0]   win_onehot_s;
    logic           owner_req_s;
    logic           limit_hit_s;
    logic           new_grant_s;
    logic [HCW-1:0] hold_inc_s;
    logic [IDW-1:0] start_s;
    logic [IDW-1:0] winner_s;

    assign request_s = bus.request;

    // Owner status without indexing request by grant_id: the one-hot grant
    // masks request directly, so the current owner is always in range.
    always_comb begin
        owner_req_s = |(grant_q & request_s);
        others_s    = request_s & ~grant_q;
    end

    // Hold counter increment with saturation; the limit is hit when the
    // owner would complete its MAX_HOLD-th consecutive cycle at this edge.
    always_comb begin
        if (MAX_HOLD == 0) begin
            hold_inc_s  = '0;
            limit_hit_s = 1'b0;
        end else if (hold_cnt_q == HOLD_MAX) begin
            hold_inc_s  = hold_cnt_q;
            limit_hit_s = 1'b1;
        end else begin
            hold_inc_s  = hold_cnt_q + 1'b1;
            limit_hit_s = (hold_inc_s == HOLD_MAX);
        end
    end

    // Search start: one past the last owner for round-robin, else index 0.
    always_comb begin
`ifdef ARB_RR_EN
        if (last_owner_q == LAST_IDX) begin
            start_s = '0;
        end else begin
            start_s = last_owner_q + 1'b1;
        end
`else
        start_s = '0;
`endif
    end

    // Next-state, next-grant and counter logic for the IDLE/GRANT machine.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;
`ifdef ARB_RR_EN
        last_owner_d  = last_owner_q;
`endif
        new_grant_s   = 1'b0;
        win_mask_s    = '0;

        case (state_q)
            ST_IDLE: begin
                if (|request_s) begin
                    new_grant_s = 1'b1;
                    win_mask_s  = request_s;
                end else begin
                    grant_d       = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    // Owner released (also covers release at hold expiry).
                    if (|others_s) begin
                        new_grant_s = 1'b1;
                        win_mask_s  = others_s;
                    end else begin
                        state_d       = ST_IDLE;
                        grant_d       = '0;
                        grant_id_d    = '0;
                        grant_valid_d = 1'b0;
                        hold_cnt_d    = '0;
                    end
                end else if (limit_hit_s && (|others_s)) begin
                    // Forced hand-off; the owner is excluded from the search.
                    new_grant_s = 1'b1;
                    win_mask_s  = others_s;
                end else begin
                    // Parked: owner keeps the grant, counter saturates.
                    hold_cnt_d = hold_inc_s;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
            end
        endcase

        winner_s     = pick_winner(win_mask_s, start_s);
        win_onehot_s = ONE_HOT0 << winner_s;

        if (new_grant_s) begin
            state_d       = ST_GRANT;
            grant_d       = win_onehot_s;
            grant_id_d    = winner_s;
            grant_valid_d = 1'b1;
            hold_cnt_d    = '0;
`ifdef ARB_RR_EN
            last_owner_d  = winner_s;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // Register all state and outputs; synchronous reset wins over request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
`ifdef ARB_RR_EN
            last_owner_q  <= LAST_IDX;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            hold_cnt_q    <= hold_cnt_d;
`ifdef ARB_RR_EN
            last_owner_q  <= last_owner_d;
`endif
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_arb_rr_n.sv
// Directed testbench for arb_rr_n with N=4, MAX_HOLD=4. Expected values
// follow the selected arbitration policy (ARB_RR_EN defined or not).
module tb_arb_rr_n;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    arb_rr_n_if #(.N(4)) ifc ();

    arb_rr_n #(
        .N        (4),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain reset pulse with no requests, used to start each scenario clean.
    task automatic do_reset();
        rst         = 1'b1;
        ifc.request = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        ifc.request = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (ifc.grant !== 4'b0000 || ifc.grant_id !== 2'd0 || ifc.grant_valid !== 1'b0) begin
                $display("FAIL reset_hold c%0d: grant=%b id=%0d valid=%b, want grant=0000 id=0 valid=0",
                         i, ifc.grant, ifc.grant_id, ifc.grant_valid);
            end else begin
                pass_cnt++;
            end
        end
        rst = 1'b0;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0001 || ifc.grant_id !== 2'd0 || ifc.grant_valid !== 1'b1) begin
            $display("FAIL reset_first_grant: grant=%b id=%0d valid=%b, want grant=0001 id=0 valid=1",
                     ifc.grant, ifc.grant_id, ifc.grant_valid);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_latency_parking();
        do_reset();
        ifc.request = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if (ifc.grant !== 4'b0100 || ifc.grant_id !== 2'd2 || ifc.grant_valid !== 1'b1) begin
                $display("FAIL park c%0d: grant=%b id=%0d valid=%b, want grant=0100 id=2 valid=1",
                         i, ifc.grant, ifc.grant_id, ifc.grant_valid);
            end else begin
                pass_cnt++;
            end
        end
        ifc.request = 4'b0000;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0000 || ifc.grant_id !== 2'd0 || ifc.grant_valid !== 1'b0) begin
            $display("FAIL park_release: grant=%b id=%0d valid=%b, want grant=0000 id=0 valid=0",
                     ifc.grant, ifc.grant_id, ifc.grant_valid);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5];
        logic [1:0] exp_id [5];
`ifdef ARB_RR_EN
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_g  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        exp_id = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif
        do_reset();
        ifc.request = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            total_cnt++;
            if (ifc.grant !== exp_g[i/4] || ifc.grant_id !== exp_id[i/4] || ifc.grant_valid !== 1'b1) begin
                $display("FAIL rotation c%0d: grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=1",
                         i, ifc.grant, ifc.grant_id, ifc.grant_valid, exp_g[i/4], exp_id[i/4]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_hold_alone();
        do_reset();
        ifc.request = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if (ifc.grant !== 4'b0001 || ifc.grant_valid !== 1'b1) begin
                $display("FAIL hold_alone c%0d: grant=%b valid=%b, want grant=0001 valid=1",
                         i, ifc.grant, ifc.grant_valid);
            end else begin
                pass_cnt++;
            end
        end
        // Counter is saturated: a newcomer takes over at the very next edge.
        ifc.request = 4'b0011;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0010 || ifc.grant_id !== 2'd1) begin
            $display("FAIL hold_saturated_handoff: grant=%b id=%0d, want grant=0010 id=1",
                     ifc.grant, ifc.grant_id);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ifc.request = 4'b0010;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0010) begin
            $display("FAIL midrst_pre: grant=%b, want 0010", ifc.grant);
        end else begin
            pass_cnt++;
        end
        rst = 1'b1;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0000 || ifc.grant_id !== 2'd0 || ifc.grant_valid !== 1'b0) begin
            $display("FAIL midrst_clear: grant=%b id=%0d valid=%b, want grant=0000 id=0 valid=0",
                     ifc.grant, ifc.grant_id, ifc.grant_valid);
        end else begin
            pass_cnt++;
        end
        rst         = 1'b0;
        ifc.request = 4'b0011;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0001 || ifc.grant_id !== 2'd0) begin
            $display("FAIL midrst_after: grant=%b id=%0d, want grant=0001 id=0",
                     ifc.grant, ifc.grant_id);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_last;
        do_reset();
        ifc.request = 4'b1010;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0010 || ifc.grant_id !== 2'd1) begin
            $display("FAIL b2b_first: grant=%b id=%0d, want grant=0010 id=1", ifc.grant, ifc.grant_id);
        end else begin
            pass_cnt++;
        end
        ifc.request = 4'b1000;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b1000 || ifc.grant_id !== 2'd3 || ifc.grant_valid !== 1'b1) begin
            $display("FAIL b2b_drop_handoff: grant=%b id=%0d valid=%b, want grant=1000 id=3 valid=1",
                     ifc.grant, ifc.grant_id, ifc.grant_valid);
        end else begin
            pass_cnt++;
        end
        // Owner drop and a fresh request on the same edge.
        ifc.request = 4'b0001;
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0001 || ifc.grant_id !== 2'd0) begin
            $display("FAIL b2b_drop_new: grant=%b id=%0d, want grant=0001 id=0", ifc.grant, ifc.grant_id);
        end else begin
            pass_cnt++;
        end
        // Policy-dependent pick: owner 1 drops with 0, 2 and 3 waiting.
        do_reset();
        ifc.request = 4'b0010;
        tick();
        ifc.request = 4'b1101;
        tick();
`ifdef ARB_RR_EN
        exp_last = 4'b0100;
`else
        exp_last = 4'b0001;
`endif
        total_cnt++;
        if (ifc.grant !== exp_last) begin
            $display("FAIL b2b_policy_pick: grant=%b, want %b", ifc.grant, exp_last);
        end else begin
            pass_cnt++;
        end
        ifc.request = 4'b0000;
        tick();
        tick();
        total_cnt++;
        if (ifc.grant !== 4'b0000 || ifc.grant_valid !== 1'b0) begin
            $display("FAIL b2b_idle: grant=%b valid=%b, want grant=0000 valid=0", ifc.grant, ifc.grant_valid);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        ifc.request = 4'b0000;
        pass_cnt    = 0;
        total_cnt   = 0;
        test_reset();
        test_latency_parking();
        test_rotation();
        test_hold_alone();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
